// File: rtl/spi_pixel_loader.sv
// Converts framed SPI bytes (command + payload) into pixel-memory writes and a
// frame show request for the WS2812B output engine.
module spi_pixel_loader #(
  parameter int NUM_PIXELS = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_cs,
  input  logic [7:0]        rx_byte,
  input  logic              rx_done,
  input  logic              rx_first,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [23:0]       pix_data,
  output logic              show,
  output logic              err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, PIX, DISCARD} state_t;

  localparam logic [16:0]       PIX_LIMIT = 17'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t              state, state_d;
  logic                rx_done_p0, cs_p0;
  logic                vld_p1, first_p1;
  logic                cs_rise;
  logic [7:0]          addr_hi, addr_hi_d;
  logic [15:0]         addr16;
  logic [ADDR_W-1:0]   cnt, cnt_d;
  logic [1:0]          idx, idx_d;
  logic [7:0]          g_byte, g_d, r_byte, r_d;
  logic                pend, pend_d;
  logic                pix_we_d, show_d, err_d;
  logic [ADDR_W-1:0]   pix_addr_d;
  logic [23:0]         pix_data_d;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // stage p0: edge detect on rx_done / spi_cs; stage p1: one-cycle byte strobe
  always_ff @(posedge clk) begin
    rx_done_p0 <= rx_done;
    cs_p0      <= spi_cs;
    if (!resetn) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      vld_p1 <= rx_done & ~rx_done_p0;
      if (rx_done & ~rx_done_p0)
        first_p1 <= rx_first;
    end
  end

  assign cs_rise = spi_cs & ~cs_p0;
  assign addr16  = {addr_hi, rx_byte};
  assign busy    = (state != IDLE);

  always_comb begin
    state_d    = state;
    addr_hi_d  = addr_hi;
    cnt_d      = cnt;
    idx_d      = idx;
    g_d        = g_byte;
    r_d        = r_byte;
    pend_d     = pend;
    pix_we_d   = 1'b0;
    show_d     = 1'b0;
    err_d      = 1'b0;
    pix_addr_d = pix_addr;
    pix_data_d = pix_data;
    if (cs_rise) begin
      // end of transaction drops any partial pixel and the byte in flight
      state_d = IDLE;
      idx_d   = '0;
      if (pend) begin
        show_d = 1'b1;
        pend_d = 1'b0;
      end
    end else if (vld_p1) begin
      if (first_p1) begin
        idx_d = '0;
        case (rx_byte)
          8'h01:   state_d = ADDR_HI;
          8'h02: begin
            pend_d  = 1'b1;
            state_d = DISCARD;
          end
          default: begin
            err_d   = 1'b1;
            state_d = DISCARD;
          end
        endcase
      end else begin
        case (state)
          ADDR_HI: begin
            addr_hi_d = rx_byte;
            state_d   = ADDR_LO;
          end
          ADDR_LO: begin
            if ({1'b0, addr16} >= PIX_LIMIT) begin
              err_d   = 1'b1;
              state_d = DISCARD;
            end else begin
              cnt_d   = addr16[ADDR_W-1:0];
              idx_d   = '0;
              state_d = PIX;
            end
          end
          PIX: begin
            case (idx)
              2'd0: begin
                g_d   = rx_byte;
                idx_d = 2'd1;
              end
              2'd1: begin
                r_d   = rx_byte;
                idx_d = 2'd2;
              end
              default: begin
                pix_we_d   = 1'b1;
                pix_addr_d = cnt;
                pix_data_d = {g_byte, r_byte, rx_byte};
                cnt_d      = wrap_inc(cnt);
                idx_d      = '0;
              end
            endcase
          end
          default: state_d = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      addr_hi  <= '0;
      cnt      <= '0;
      idx      <= '0;
      g_byte   <= '0;
      r_byte   <= '0;
      pend     <= 1'b0;
      pix_we   <= 1'b0;
      show     <= 1'b0;
      err      <= 1'b0;
      pix_addr <= '0;
      pix_data <= '0;
    end else begin
      state    <= state_d;
      addr_hi  <= addr_hi_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      g_byte   <= g_d;
      r_byte   <= r_d;
      pend     <= pend_d;
      pix_we   <= pix_we_d;
      show     <= show_d;
      err      <= err_d;
      pix_addr <= pix_addr_d;
      pix_data <= pix_data_d;
    end
  end

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Directed bench for spi_pixel_loader: byte-level SPI transactions with
// hand-computed pixel writes, show/err pulses and latencies.
module tb_spi_pixel_loader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_cs = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_done = 1'b0;
  logic        rx_first = 1'b0;
  logic        pix_we;
  logic [7:0]  pix_addr;
  logic [23:0] pix_data;
  logic        show, err, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_rise = 0;
  int cs_cyc = 0;

  int          we_addr[$];
  logic [23:0] we_data[$];
  int          we_cyc[$];
  int show_n = 0, show_cyc = 0, err_n = 0, both_n = 0, consec_n = 0;
  logic we_prev = 1'b0;

  spi_pixel_loader #(.NUM_PIXELS(256), .ADDR_W(8)) dut (
    .clk(clk), .resetn(resetn), .spi_cs(spi_cs), .rx_byte(rx_byte),
    .rx_done(rx_done), .rx_first(rx_first), .pix_we(pix_we),
    .pix_addr(pix_addr), .pix_data(pix_data), .show(show), .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_we) begin
      we_addr.push_back(int'(pix_addr));
      we_data.push_back(pix_data);
      we_cyc.push_back(cyc);
    end
    if (show) begin
      show_n   = show_n + 1;
      show_cyc = cyc;
    end
    if (err) err_n = err_n + 1;
    if (pix_we && show) both_n = both_n + 1;
    if (pix_we && we_prev) consec_n = consec_n + 1;
    we_prev = pix_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic f, input int hold);
    rx_byte   = b;
    rx_first  = f;
    rx_done   = 1'b1;
    last_rise = cyc;
    repeat (hold) @(negedge clk);
    rx_done  = 1'b0;
    rx_first = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_start();
    spi_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_end();
    spi_cs = 1'b1;
    cs_cyc = cyc;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    @(negedge clk);
    #1;
    we_addr.delete();
    we_data.delete();
    we_cyc.delete();
    show_n = 0;
    err_n  = 0;
  endtask

  initial begin
    int b0, b1;
    b0 = 0;
    b1 = 0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pix_we", pix_we, 0);
    chk("rst_show", show, 0);
    chk("rst_err", err, 0);
    chk("rst_pix_addr", pix_addr, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;

    // two pixels from address 5
    clr();
    cs_start();
    send(8'h01, 1'b1, 1);
    #1 chk("wr_busy", busy, 1);
    send(8'h00, 1'b0, 1);
    send(8'h05, 1'b0, 1);
    send(8'h11, 1'b0, 1);
    send(8'h22, 1'b0, 1);
    send(8'h33, 1'b0, 1);
    b0 = last_rise;
    send(8'h44, 1'b0, 1);
    send(8'h55, 1'b0, 1);
    send(8'h66, 1'b0, 1);
    b1 = last_rise;
    cs_end();
    chk("wr_count", we_addr.size(), 2);
    chk("wr0_addr", we_addr[0], 5);
    chk("wr0_data", we_data[0], 24'h112233);
    chk("wr0_lat", we_cyc[0] - b0, 2);
    chk("wr1_addr", we_addr[1], 6);
    chk("wr1_data", we_data[1], 24'h445566);
    chk("wr1_lat", we_cyc[1] - b1, 2);
    chk("wr_noshow", show_n, 0);
    chk("wr_idle", busy, 0);

    // wrap from last address
    clr();
    cs_start();
    send(8'h01, 1'b1, 1);
    send(8'h00, 1'b0, 1);
    send(8'hFF, 1'b0, 1);
    send(8'hA1, 1'b0, 1);
    send(8'hA2, 1'b0, 1);
    send(8'hA3, 1'b0, 1);
    send(8'hB1, 1'b0, 1);
    send(8'hB2, 1'b0, 1);
    send(8'hB3, 1'b0, 1);
    cs_end();
    chk("wrap_count", we_addr.size(), 2);
    chk("wrap0_addr", we_addr[0], 255);
    chk("wrap0_data", we_data[0], 24'hA1A2A3);
    chk("wrap1_addr", we_addr[1], 0);
    chk("wrap1_data", we_data[1], 24'hB1B2B3);

    // out-of-range address
    clr();
    cs_start();
    send(8'h01, 1'b1, 1);
    send(8'h01, 1'b0, 1);
    send(8'h00, 1'b0, 1);
    send(8'h11, 1'b0, 1);
    send(8'h22, 1'b0, 1);
    send(8'h33, 1'b0, 1);
    #1 chk("badaddr_busy", busy, 1);
    cs_end();
    chk("badaddr_err", err_n, 1);
    chk("badaddr_nowe", we_addr.size(), 0);
    chk("badaddr_idle", busy, 0);

    // unknown command
    clr();
    cs_start();
    send(8'h7F, 1'b1, 1);
    send(8'h11, 1'b0, 1);
    send(8'h22, 1'b0, 1);
    send(8'h33, 1'b0, 1);
    #1 chk("badcmd_busy", busy, 1);
    cs_end();
    chk("badcmd_err", err_n, 1);
    chk("badcmd_nowe", we_addr.size(), 0);

    // show request
    clr();
    cs_start();
    send(8'h02, 1'b1, 1);
    send(8'hAA, 1'b0, 1);
    cs_end();
    chk("show_count", show_n, 1);
    chk("show_lat", show_cyc - cs_cyc, 1);
    chk("show_noerr", err_n, 0);

    // abort mid-pixel, then clean write at 0
    clr();
    cs_start();
    send(8'h01, 1'b1, 1);
    send(8'h00, 1'b0, 1);
    send(8'h00, 1'b0, 1);
    send(8'h11, 1'b0, 1);
    send(8'h22, 1'b0, 1);
    cs_end();
    chk("abort_nowe", we_addr.size(), 0);
    clr();
    cs_start();
    send(8'h01, 1'b1, 1);
    send(8'h00, 1'b0, 1);
    send(8'h00, 1'b0, 1);
    send(8'h01, 1'b0, 1);
    send(8'h02, 1'b0, 1);
    send(8'h03, 1'b0, 1);
    cs_end();
    chk("fresh_count", we_addr.size(), 1);
    chk("fresh_addr", we_addr[0], 0);
    chk("fresh_data", we_data[0], 24'h010203);

    // rx_done held 5 cycles per byte, reset mid-pixel
    clr();
    cs_start();
    send(8'h01, 1'b1, 5);
    send(8'h00, 1'b0, 5);
    send(8'h10, 1'b0, 5);
    send(8'hAA, 1'b0, 5);
    send(8'hBB, 1'b0, 5);
    send(8'hCC, 1'b0, 5);
    send(8'hDD, 1'b0, 5);
    send(8'hEE, 1'b0, 5);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_pix_we", pix_we, 0);
    chk("mrst_pix_addr", pix_addr, 0);
    chk("mrst_pix_data", pix_data, 0);
    chk("mrst_busy", busy, 0);
    resetn = 1'b1;
    send(8'h11, 1'b0, 5);
    send(8'h22, 1'b0, 5);
    send(8'h33, 1'b0, 5);
    #1 chk("postrst_idle", busy, 0);
    send(8'h01, 1'b1, 5);
    send(8'h00, 1'b0, 5);
    send(8'h03, 1'b0, 5);
    send(8'h44, 1'b0, 5);
    send(8'h55, 1'b0, 5);
    send(8'h66, 1'b0, 5);
    cs_end();
    chk("hold_count", we_addr.size(), 2);
    chk("hold0_addr", we_addr[0], 16);
    chk("hold0_data", we_data[0], 24'hAABBCC);
    chk("hold1_addr", we_addr[1], 3);
    chk("hold1_data", we_data[1], 24'h445566);
    chk("hold_noerr", err_n, 0);

    chk("we_show_overlap", both_n, 0);
    chk("we_back_to_back", consec_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_pixel_loader.md
Name: spi_pixel_loader

Overview:
- Sits directly downstream of the SPI slave byte receiver in the WS2812B display path.
- Turns the received byte stream, framed by chip select and the first-byte flag, into pixel-memory write cycles, and into a frame "show" request for the WS2812B output engine.
- Each transaction is one command byte followed by command-specific payload.

Parameters:
- NUM_PIXELS, 256: number of pixel-memory entries; legal addresses are 0..NUM_PIXELS-1.
- ADDR_W, 8: pixel address width; must satisfy 2^ADDR_W >= NUM_PIXELS.

Ports:
- clk  in  1  system clock; the only clock.
- resetn  in  1  synchronous, active-low reset.
- spi_cs  in  1  SPI chip select; low = transaction active.
- rx_byte  in  8  received byte from the SPI slave.
- rx_done  in  1  byte-complete flag from the SPI slave; level, may stay high several cycles.
- rx_first  in  1  high while the current byte is the first of the transaction.
- pix_we  out  1  pixel write strobe, one cycle.
- pix_addr  out  ADDR_W  pixel write address.
- pix_data  out  24  pixel value {G,R,B}.
- show  out  1  one-cycle frame-latch request.
- err  out  1  one-cycle pulse on a protocol error.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset (resetn low at a clk edge) forces the following, and overrides every other event:
  - state = IDLE;
  - pix_we, show, err = 0; pix_addr = 0; pix_data = 0;
  - internal address counter, byte index and pending-show flag cleared.
- Byte detection:
  - Cycle T: rx_done = 1 while the registered previous rx_done = 0. Latch rx_first at T.
  - Cycle T+1: sample rx_byte. This is the internal byte strobe.
  - rx_done held high produces exactly one strobe.
- A strobe with latched first = 1 is always a command byte: enter CMD decode from any state and drop any partial pixel.
- Commands:
  - 0x01 WRITE: go to ADDR_HI.
  - 0x02 SHOW: set pending-show; go to DISCARD.
  - Any other value: pulse err at the next cycle; go to DISCARD.
- ADDR_HI: store the byte as addr[15:8]; go to ADDR_LO.
- ADDR_LO:
  - Form the 16-bit address.
  - If it is >= NUM_PIXELS: pulse err, go to DISCARD.
  - Otherwise load the counter with addr[ADDR_W-1:0], set the byte index to 0, go to PIX.
- PIX: bytes arrive in order G, R, B (index 0, 1, 2).
  - On the B byte, at the next cycle (T+2 of that byte): pix_we = 1, pix_addr = counter, pix_data = {G,R,B}. The counter then increments.
  - Counter wraps from NUM_PIXELS-1 to 0.
  - pix_we is never high for two consecutive cycles.
  - pix_addr and pix_data hold their values after the write.
- DISCARD: ignore all non-first bytes.
- A strobe with first = 0 while in IDLE is ignored; no err.
- spi_cs deassertion:
  - Rising edge of spi_cs in any state returns to IDLE at the next cycle.
  - A partial pixel (1 or 2 bytes) is dropped and no write occurs.
  - If pending-show is set, pulse show on that same cycle and clear pending-show.
- Simultaneous spi_cs rise and byte strobe: the cs rise wins and the byte is dropped. A B byte whose pix_we is already scheduled still completes.
- A transaction containing SHOW produces exactly one show pulse, even if more bytes follow.
- pix_we and show can never be high in the same cycle.

Test Plan:
- Write 2 pixels: cs low; bytes 0x01, 0x00, 0x05, 0x11, 0x22, 0x33, 0x44, 0x55, 0x66; cs high.
  - Required: pix_we at addr 5 with 0x112233, then at addr 6 with 0x445566.
  - Each pix_we occurs 2 cycles after the B-byte rx_done rise; exactly 2 pulses; no show.
- Wrap with NUM_PIXELS = 256: start at 0x00FF, 2 pixels.
  - Required: writes to 255, then 0.
- Bad address 0x0100, or unknown command 0x7F.
  - Required: one err pulse; no pix_we for the remaining payload; busy until cs rises.
- SHOW: bytes 0x02, 0xAA; then cs high.
  - Required: show = 1 for one cycle, one cycle after the cs rise; err stays 0.
- Abort mid-pixel: 0x01, 0x00, 0x00, 0x11, 0x22, cs high.
  - Required: no pix_we.
  - Next transaction writing 0x010203 at addr 0 then writes {01,02,03}, with no stale bytes.
- rx_done held high for 5 cycles per byte, plus resetn pulled low mid-PIX.
  - Required: one strobe per byte.
  - After reset, all outputs are 0 and state is IDLE; the following payload bytes are ignored until a new first byte arrives.
